// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder                                                              |
// | Bit-serial memory responder with byte RAM; optional low-region write       |
// | protection enabled by defining MEM_RESPONDER_ROM_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_responder #(
  parameter int IO_BITS    = 2,
  parameter int MEM_LOG2   = 6,
  parameter int READ_DELAY = 1,
  parameter int ROM_BYTES  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IO_BITS-1:0]  tx_pins,
  output logic [IO_BITS-1:0]  rx_pins,
  output logic                busy,
  output logic                wp_hit,
  input  logic                load_en,
  input  logic [MEM_LOG2-1:0] load_addr,
  input  logic [7:0]          load_data
);

  localparam int c_DEPTH = 1 << MEM_LOG2;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ADDR  = 3'd1;
  localparam logic [2:0] c_WDATA = 3'd2;
  localparam logic [2:0] c_DELAY = 3'd3;
  localparam logic [2:0] c_RSB   = 3'd4;
  localparam logic [2:0] c_RDATA = 3'd5;

  localparam logic [IO_BITS-1:0] c_TX_READ_16  = IO_BITS'(1);
  localparam logic [IO_BITS-1:0] c_TX_WRITE_8  = IO_BITS'(2);
  localparam logic [IO_BITS-1:0] c_TX_WRITE_16 = IO_BITS'(3);
  localparam logic [IO_BITS-1:0] c_RX_SB_READ  = IO_BITS'(1);

  localparam logic [4:0] c_W16_LAST = 5'(16 / IO_BITS - 1);
  localparam logic [4:0] c_W8_LAST  = 5'(8 / IO_BITS - 1);
  localparam logic [4:0] c_DLY_LAST = 5'(READ_DELAY - 1);
  localparam logic [31:0] c_ROM_LIMIT = 32'(ROM_BYTES);

`ifdef MEM_RESPONDER_ROM_EN
  localparam logic c_ROM_EN = 1'b1;
`else
  localparam logic c_ROM_EN = 1'b0;
`endif

  logic [2:0]            r_state;
  logic [IO_BITS-1:0]    r_hdr;
  logic [4:0]            r_cnt;
  logic [15:0]           r_addr;
  logic [15-IO_BITS:0]   r_wdata;
  logic [15:0]           r_rdata;
  logic [IO_BITS-1:0]    r_rx;
  logic                  r_wp;
  logic [7:0]            r_mem [c_DEPTH];

  logic [15:0]           w_addr_shift;
  logic [15:0]           w_wdata_shift;
  logic                  w_is_w8;
  logic                  w_wdata_last;
  logic                  w_commit;
  logic [MEM_LOG2-1:0]   w_wa_lo, w_wa_hi;
  logic [7:0]            w_wd_lo, w_wd_hi;
  logic                  w_prot_lo, w_prot_hi;
  logic                  w_we_lo, w_we_hi, w_drop;
  logic [MEM_LOG2-1:0]   w_ra_lo, w_ra_hi;
  logic [15:0]           w_rword;

  // Chunks arrive LSB first, so new chunks enter at the top and slide down.
  assign w_addr_shift  = {tx_pins, r_addr[15:IO_BITS]};
  assign w_wdata_shift = {tx_pins, r_wdata};

  assign w_is_w8      = (r_hdr == c_TX_WRITE_8);
  assign w_wdata_last = (r_cnt == (w_is_w8 ? c_W8_LAST : c_W16_LAST));
  assign w_commit     = rst_n && (r_state == c_WDATA) && w_wdata_last;

  assign w_wa_lo = r_addr[MEM_LOG2-1:0];
  assign w_wa_hi = w_wa_lo + MEM_LOG2'(1);
  // A WRITE_8 payload has only shifted halfway, so its byte sits in the top half.
  assign w_wd_lo = w_is_w8 ? w_wdata_shift[15:8] : w_wdata_shift[7:0];
  assign w_wd_hi = w_wdata_shift[15:8];

  assign w_prot_lo = c_ROM_EN && ({{(32-MEM_LOG2){1'b0}}, w_wa_lo} < c_ROM_LIMIT);
  assign w_prot_hi = c_ROM_EN && ({{(32-MEM_LOG2){1'b0}}, w_wa_hi} < c_ROM_LIMIT);
  assign w_we_lo   = w_commit && !w_prot_lo;
  assign w_we_hi   = w_commit && !w_is_w8 && !w_prot_hi;
  assign w_drop    = w_commit && (w_prot_lo || (!w_is_w8 && w_prot_hi));

  // With no read delay the snapshot happens on the last address edge itself.
  assign w_ra_lo = (r_state == c_ADDR) ? w_addr_shift[MEM_LOG2-1:0] : r_addr[MEM_LOG2-1:0];
  assign w_ra_hi = w_ra_lo + MEM_LOG2'(1);
  assign w_rword = {r_mem[w_ra_hi], r_mem[w_ra_lo]};

  // Protocol writes follow the backdoor so they win a same-byte collision.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
    if (w_we_lo) r_mem[w_wa_lo] <= w_wd_lo;
    if (w_we_hi) r_mem[w_wa_hi] <= w_wd_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_hdr   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rx    <= '0;
      r_wp    <= 1'b0;
    end else begin
      r_wp <= w_drop;
      case (r_state)
        c_IDLE: begin
          r_rx <= '0;
          if (tx_pins != '0) begin
            r_hdr   <= tx_pins;
            r_cnt   <= '0;
            r_state <= c_ADDR;
          end
        end
        c_ADDR: begin
          r_addr <= w_addr_shift;
          if (r_cnt == c_W16_LAST) begin
            r_cnt <= '0;
            if (r_hdr == c_TX_READ_16) begin
              if (READ_DELAY == 0) begin
                r_rdata <= w_rword;
                r_rx    <= c_RX_SB_READ;
                r_state <= c_RSB;
              end else begin
                r_state <= c_DELAY;
              end
            end else if (r_hdr == c_TX_WRITE_8 || r_hdr == c_TX_WRITE_16) begin
              r_state <= c_WDATA;
            end else begin
              r_state <= c_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        c_WDATA: begin
          r_wdata <= w_wdata_shift[15:IO_BITS];
          if (w_wdata_last) begin
            r_cnt   <= '0;
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        c_DELAY: begin
          if (r_cnt == c_DLY_LAST) begin
            r_cnt   <= '0;
            r_rdata <= w_rword;
            r_rx    <= c_RX_SB_READ;
            r_state <= c_RSB;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        c_RSB: begin
          r_rx    <= r_rdata[IO_BITS-1:0];
          r_rdata <= r_rdata >> IO_BITS;
          r_cnt   <= '0;
          r_state <= c_RDATA;
        end
        c_RDATA: begin
          if (r_cnt == c_W16_LAST) begin
            r_rx    <= '0;
            r_cnt   <= '0;
            r_state <= c_IDLE;
          end else begin
            r_rx    <= r_rdata[IO_BITS-1:0];
            r_rdata <= r_rdata >> IO_BITS;
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign rx_pins = r_rx;
  assign busy    = (r_state != c_IDLE);
  assign wp_hit  = r_wp;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_responder                                                           |
// | Directed bench: one instance per READ_DELAY of interest (1, 0, 15).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] tx;
  int         sel;
  logic       load_en;
  logic [5:0] load_addr;
  logic [7:0] load_data;

  logic [1:0] tx_a, tx_b, tx_c;
  logic [1:0] rx_a, rx_b, rx_c;
  logic       busy_a, busy_b, busy_c;
  logic       wp_a, wp_b, wp_c;
  logic [1:0] rx_s;
  logic       busy_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign tx_a   = (sel == 0) ? tx : 2'b00;
  assign tx_b   = (sel == 1) ? tx : 2'b00;
  assign tx_c   = (sel == 2) ? tx : 2'b00;
  assign rx_s   = (sel == 0) ? rx_a : (sel == 1) ? rx_b : rx_c;
  assign busy_s = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;

  mem_responder #(.IO_BITS(2), .MEM_LOG2(6), .READ_DELAY(1), .ROM_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_pins(tx_a), .rx_pins(rx_a), .busy(busy_a),
    .wp_hit(wp_a), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  mem_responder #(.IO_BITS(2), .MEM_LOG2(6), .READ_DELAY(0), .ROM_BYTES(16)) dut_d0 (
    .clk(clk), .rst_n(rst_n), .tx_pins(tx_b), .rx_pins(rx_b), .busy(busy_b),
    .wp_hit(wp_b), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  mem_responder #(.IO_BITS(2), .MEM_LOG2(6), .READ_DELAY(15), .ROM_BYTES(16)) dut_d15 (
    .clk(clk), .rst_n(rst_n), .tx_pins(tx_c), .rx_pins(rx_c), .busy(busy_c),
    .wp_hit(wp_c), .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    tx = v;
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic hdr_addr(input logic [1:0] h, input logic [15:0] a);
    drive(h);
    for (int k = 0; k < 8; k++) drive(a[2*k +: 2]);
  endtask

  task automatic write16(input logic [15:0] a, input logic [15:0] d);
    hdr_addr(2'd3, a);
    for (int k = 0; k < 8; k++) drive(d[2*k +: 2]);
  endtask

  task automatic write8(input logic [15:0] a, input logic [7:0] d);
    hdr_addr(2'd2, a);
    for (int k = 0; k < 4; k++) drive(d[2*k +: 2]);
  endtask

  task automatic read16(input logic [15:0] a, input int dly, input logic [15:0] exp, input string nm);
    logic [15:0] word;
    hdr_addr(2'd1, a);
    for (int k = 0; k < dly; k++) begin
      drive(2'd0);
      n_chk++;
      if (rx_s !== 2'd0) begin
        n_fail++;
        $display("FAIL %s delay cycle %0d: rx_pins=%0d expected 0", nm, k, rx_s);
      end
    end
    drive(2'd0);
    n_chk++;
    if (rx_s !== 2'd1) begin
      n_fail++;
      $display("FAIL %s start symbol: rx_pins=%0d expected 1", nm, rx_s);
    end
    word = '0;
    for (int k = 0; k < 8; k++) begin
      drive(2'd0);
      word[2*k +: 2] = rx_s;
    end
    n_chk++;
    if (word !== exp) begin
      n_fail++;
      $display("FAIL %s read data: got 0x%04h expected 0x%04h", nm, word, exp);
    end
    drive(2'd0);
    n_chk++;
    if (busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy after read: got %0b expected 0", nm, busy_s);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({rx_a, rx_b, rx_c} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset rx_pins: got %b expected 000000", {rx_a, rx_b, rx_c});
    end
    n_chk++;
    if ({busy_a, busy_b, busy_c} !== 3'd0) begin
      n_fail++;
      $display("FAIL reset busy: got %b expected 000", {busy_a, busy_b, busy_c});
    end
    n_chk++;
    if ({wp_a, wp_b, wp_c} !== 3'd0) begin
      n_fail++;
      $display("FAIL reset wp_hit: got %b expected 000", {wp_a, wp_b, wp_c});
    end
    rst_n = 1'b1;
    drive(2'd0);
  endtask

  // Read header follows the last write chunk with no idle cycle.
  task automatic test_back_to_back();
    sel = 0;
    write16(16'h0020, 16'hBEEF);
    read16(16'h0020, 1, 16'hBEEF, "w16_then_read");
  endtask

  task automatic test_write8();
    load(6'd5, 8'h11);
    load(6'd6, 8'h22);
    sel = 0;
    write8(16'h0005, 8'hA5);
    drive(2'd0);
    read16(16'h0005, 1, 16'h22A5, "w8_read");
  endtask

  task automatic test_wrap();
    load(6'd63, 8'h34);
    load(6'd0, 8'h12);
    sel = 0;
    read16(16'h003F, 1, 16'h1234, "wrap_3f");
    read16(16'h0445, 1, 16'h22A5, "alias_445");
  endtask

  task automatic test_read_delay();
    sel = 1;
    read16(16'h0005, 0, 16'h2211, "delay0");
    sel = 2;
    read16(16'h003F, 15, 16'h1234, "delay15");
    sel = 0;
  endtask

  task automatic test_reset_abort();
    sel = 0;
    // Read aborted while the third data chunk (0xBEEF chunk 2 = 2) is on the pins.
    hdr_addr(2'd1, 16'h0020);
    for (int k = 0; k < 5; k++) drive(2'd0);
    n_chk++;
    if (rx_s !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_read chunk2: rx_pins=%0d expected 2", rx_s);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (rx_s !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_read rx_pins: got %0d expected 0", rx_s);
    end
    n_chk++;
    if (busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_read busy: got %0b expected 0", busy_s);
    end
    drive(2'd0);
    rst_n = 1'b1;
    drive(2'd0);
    read16(16'h0020, 1, 16'hBEEF, "after_read_abort");
    // WRITE_16 aborted at its third data chunk must leave the bytes intact.
    hdr_addr(2'd3, 16'h0020);
    drive(2'h0);
    drive(2'h1);
    drive(2'h3);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_write busy: got %0b expected 0", busy_s);
    end
    drive(2'd0);
    drive(2'd0);
    rst_n = 1'b1;
    drive(2'd0);
    read16(16'h0020, 1, 16'hBEEF, "after_write_abort");
  endtask

  task automatic test_rom();
    logic        exp_wp;
    logic [15:0] exp_word;
`ifdef MEM_RESPONDER_ROM_EN
    exp_wp   = 1'b1;
    exp_word = 16'hCD77;
`else
    exp_wp   = 1'b0;
    exp_word = 16'hCDAB;
`endif
    load(6'd15, 8'h77);
    load(6'd16, 8'h66);
    sel = 0;
    write16(16'h000F, 16'hCDAB);
    drive(2'd0);
    n_chk++;
    if (wp_a !== exp_wp) begin
      n_fail++;
      $display("FAIL rom wp_hit pulse: got %0b expected %0b", wp_a, exp_wp);
    end
    drive(2'd0);
    n_chk++;
    if (wp_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rom wp_hit after pulse: got %0b expected 0", wp_a);
    end
    read16(16'h000F, 1, exp_word, "rom_straddle");
  endtask

  initial begin
    rst_n     = 1'b0;
    tx        = 2'd0;
    sel       = 0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    test_reset();
    test_back_to_back();
    test_write8();
    test_wrap();
    test_read_delay();
    test_reset_abort();
    test_rom();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
